// File: rtl/simple_alu.sv
// Registered bitwise logic unit: AND / OR / NOT A / NOT B selected by sel, one-cycle latency.
// Optional registered zero/parity status flags when SIMPLE_ALU_STATUS_EN is defined.
module simple_alu #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
`ifdef SIMPLE_ALU_STATUS_EN
    output logic             zero,
    output logic             parity,
`endif
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r;

    always_comb begin
        r = '0;
        case (sel)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = ~a;
            default: r = ~b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= r;
        end
    end

`ifdef SIMPLE_ALU_STATUS_EN
    // Flags derive from r, not the old out, so they always agree with the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero   <= 1'b1;
            parity <= 1'b0;
        end else begin
            zero   <= (r == '0);
            parity <= ^r;
        end
    end
`endif

endmodule

// File: tb/tb_simple_alu.sv
// Self-checking bench for simple_alu: 1-bit and 8-bit instances against a per-bit arithmetic model.
// Status-flag checks are active when SIMPLE_ALU_STATUS_EN is defined.
module tb_simple_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       a1, b1;
    logic [7:0] a8, b8;
    logic       out1;
    logic [7:0] out8;
`ifdef SIMPLE_ALU_STATUS_EN
    logic       zero1, parity1, zero8, parity8;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    simple_alu #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .a      (a1),
        .b      (b1),
        .sel    (sel),
`ifdef SIMPLE_ALU_STATUS_EN
        .zero   (zero1),
        .parity (parity1),
`endif
        .out    (out1)
    );

    simple_alu #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .a      (a8),
        .b      (b8),
        .sel    (sel),
`ifdef SIMPLE_ALU_STATUS_EN
        .zero   (zero8),
        .parity (parity8),
`endif
        .out    (out8)
    );

    // Reference: each result bit from the count of set operand bits, complements by subtraction.
    function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input int s, input int w);
        logic [63:0] res;
        int n, bitv;
        res = '0;
        for (int i = 0; i < w; i++) begin
            n = int'(x[i]) + int'(y[i]);
            case (s)
                0:       bitv = (n == 2) ? 1 : 0;
                1:       bitv = (n >= 1) ? 1 : 0;
                2:       bitv = 1 - int'(x[i]);
                default: bitv = 1 - int'(y[i]);
            endcase
            res[i] = (bitv == 1);
        end
        return res;
    endfunction

    function automatic logic model_parity(input logic [63:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < 64; i++) ones += int'(v[i]);
        return (ones % 2) == 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compute expectations from the inputs present before the edge, then check after it.
    task automatic tick_check(input string tag);
        logic [63:0] e1, e8;
        if (rst) begin
            e1 = '0;
            e8 = '0;
        end else begin
            e1 = model(64'(a1), 64'(b1), int'(sel), 1);
            e8 = model(64'(a8), 64'(b8), int'(sel), 8);
        end
        @(posedge clk);
        #1;
        chk({tag, ".out1"}, 64'(out1), e1);
        chk({tag, ".out8"}, 64'(out8), e8);
`ifdef SIMPLE_ALU_STATUS_EN
        chk({tag, ".zero1"},   64'(zero1),   64'(e1 == 64'd0));
        chk({tag, ".parity1"}, 64'(parity1), 64'(model_parity(e1)));
        chk({tag, ".zero8"},   64'(zero8),   64'(e8 == 64'd0));
        chk({tag, ".parity8"}, 64'(parity8), 64'(model_parity(e8)));
`endif
    endtask

    task automatic drive(input logic r, input logic x1, input logic y1,
                         input logic [7:0] x8, input logic [7:0] y8, input logic [1:0] s);
        rst = r; a1 = x1; b1 = y1; a8 = x8; b8 = y8; sel = s;
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 2'b00);

        // Reset dominates operands, then release gives AND of 1,1.
        tick_check("reset");
        chk("reset_const_out1", 64'(out1), 64'd0);
        chk("reset_const_out8", 64'(out8), 64'd0);
`ifdef SIMPLE_ALU_STATUS_EN
        chk("reset_const_zero",   64'(zero1),   64'd1);
        chk("reset_const_parity", 64'(parity1), 64'd0);
`endif
        drive(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 2'b00);
        tick_check("release");
        chk("release_const", 64'(out1), 64'd1);

        // AND / OR
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 2'b01);
        tick_check("or01");
        chk("or01_const", 64'(out1), 64'd1);
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 2'b00);
        tick_check("and01");
        chk("and01_const", 64'(out1), 64'd0);

        // NOT A, then NOT B; latency: sel changes mid-cycle, out holds until edge
        drive(1'b0, 1'b0, 1'b1, 8'h0F, 8'hF0, 2'b10);
        tick_check("nota");
        chk("nota_const", 64'(out1), 64'd1);
        #3;
        sel = 2'b11;
        #1;
        chk("lat_hold_out1", 64'(out1), 64'd1);
        chk("lat_hold_out8", 64'(out8), 64'hF0);
        tick_check("notb");
        chk("notb_const", 64'(out1), 64'd0);

        // Wide directed vectors
        for (int s = 0; s < 4; s++) begin
            logic [7:0] golden [4];
            golden[0] = 8'h30; golden[1] = 8'hFC; golden[2] = 8'h0F; golden[3] = 8'hC3;
            drive(1'b0, 1'b0, 1'b0, 8'hF0, 8'h3C, 2'(s));
            tick_check("wide");
            chk($sformatf("wide_const_sel%0d", s), 64'(out8), 64'(golden[s]));
        end
`ifdef SIMPLE_ALU_STATUS_EN
        chk("wide_c3_parity", 64'(parity8), 64'd0);
`endif

        // Mid-operation reset while cycling opcodes
        for (int i = 0; i < 8; i++) begin
            drive((i == 3), 1'b1, 1'b0, 8'hA5, 8'h5A, 2'(i % 4));
            tick_check($sformatf("midrst%0d", i));
            if (i == 3) chk("midrst_const", 64'(out8), 64'd0);
        end

        // Randomized traffic with sparse resets
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), 2'($urandom));
            tick_check("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
